// File: rtl/add_4.sv
// Purpose: PC-increment unit; forms pc_in + INC combinationally and keeps a registered copy with status flags.
// Latency: pc_out/carry/misaligned are zero-cycle; pc_out_q/carry_q/misaligned_q/valid_q are one cycle.
// Backpressure: none; no handshake, the registered side samples every clock edge.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset (registered side only)
//   pc_in               current program counter
//   pc_out, carry       (pc_in + INC) mod 2^WIDTH and the carry-out of that sum
//   misaligned          pc_in[1:0] != 0; reported only, no alignment correction applied
//   *_q, valid_q        registered copies; valid_q rises on the first non-reset edge
module add_4 #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             carry,
    output logic             misaligned,
    output logic [WIDTH-1:0] pc_out_q,
    output logic             carry_q,
    output logic             misaligned_q,
    output logic             valid_q
);

    // One extra bit on the adder so the carry-out falls out of a plain '+'
    // without any separate overflow logic on the critical path.
    localparam logic [WIDTH:0] INC_EXT = (WIDTH + 1)'(INC);

    logic [WIDTH:0] sum;

    assign sum        = {1'b0, pc_in} + INC_EXT;
    assign pc_out     = sum[WIDTH-1:0];
    assign carry      = sum[WIDTH];
    assign misaligned = |pc_in[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out_q     <= '0;
            carry_q      <= 1'b0;
            misaligned_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            pc_out_q     <= pc_out;
            carry_q      <= carry;
            misaligned_q <= misaligned;
            valid_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_4.sv
// Purpose: self-checking bench for add_4 (default 32-bit/+4 and a 16-bit/+2 instance).
// Latency: checks combinational outputs with no clock, then registered outputs one edge after stimulus.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_add_4;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic        carry;
    logic        misaligned;
    logic [31:0] pc_out_q;
    logic        carry_q;
    logic        misaligned_q;
    logic        valid_q;

    logic [15:0] pc16_in;
    logic [15:0] pc16_out;
    logic        carry16;
    logic        misaligned16;
    logic [15:0] pc16_out_q;
    logic        carry16_q;
    logic        misaligned16_q;
    logic        valid16_q;

    int n_assert;
    int n_fail;

    add_4 dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_out       (pc_out),
        .carry        (carry),
        .misaligned   (misaligned),
        .pc_out_q     (pc_out_q),
        .carry_q      (carry_q),
        .misaligned_q (misaligned_q),
        .valid_q      (valid_q)
    );

    add_4 #(.WIDTH(16), .INC(2)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc16_in),
        .pc_out       (pc16_out),
        .carry        (carry16),
        .misaligned   (misaligned16),
        .pc_out_q     (pc16_out_q),
        .carry_q      (carry16_q),
        .misaligned_q (misaligned16_q),
        .valid_q      (valid16_q)
    );

    // Clock only runs once clk_en is set, so the first phase is truly clockless.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain wide arithmetic, {misaligned, carry, sum}.
    function automatic logic [33:0] model(input logic [31:0] pc);
        longint unsigned s;
        logic [31:0]     lo;
        s  = longint'(pc) + 64'd4;
        lo = 32'(s % 64'h1_0000_0000);
        return {(pc % 4) != 0, s >= 64'h1_0000_0000, lo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        logic [33:0] m;
        m = model(pc_in);
        chk({tag, ".pc_out"}, 64'(pc_out), 64'(m[31:0]));
        chk({tag, ".carry"}, 64'(carry), 64'(m[32]));
        chk({tag, ".misaligned"}, 64'(misaligned), 64'(m[33]));
    endtask

    // Advance one edge and sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [33:0] m;
        logic        r;
        n_assert = 0;
        n_fail   = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        pc_in    = 32'h0;
        pc16_in  = 16'h0;

        // Combinational, no clock running.
        pc_in = 32'h2;  #10;
        chk("c2.pc_out", 64'(pc_out), 64'h6);
        chk("c2.mis", 64'(misaligned), 64'h1);
        chk("c2.carry", 64'(carry), 64'h0);
        pc_in = 32'h0;  #10;
        chk("c0.pc_out", 64'(pc_out), 64'h4);
        chk("c0.mis", 64'(misaligned), 64'h0);
        pc_in = 32'hA;  #10;
        chk("cA.pc_out", 64'(pc_out), 64'hE);
        chk("cA.mis", 64'(misaligned), 64'h1);
        pc_in = 32'hF;  #10;
        chk("cF.pc_out", 64'(pc_out), 64'h13);
        chk("cF.mis", 64'(misaligned), 64'h1);

        // Wrap boundaries.
        pc_in = 32'hFFFF_FFFC; #10;
        chk("wFC.pc_out", 64'(pc_out), 64'h0);
        chk("wFC.carry", 64'(carry), 64'h1);
        pc_in = 32'hFFFF_FFFF; #10;
        chk("wFF.pc_out", 64'(pc_out), 64'h3);
        chk("wFF.carry", 64'(carry), 64'h1);
        pc_in = 32'h7FFF_FFFC; #10;
        chk("w7F.pc_out", 64'(pc_out), 64'h8000_0000);
        chk("w7F.carry", 64'(carry), 64'h0);

        // Parameterised instance.
        pc16_in = 16'hFFFF; #10;
        chk("p16.pc_out", 64'(pc16_out), 64'h0001);
        chk("p16.carry", 64'(carry16), 64'h1);
        pc16_in = 16'h1234; #10;
        chk("p16b.pc_out", 64'(pc16_out), 64'h1236);
        chk("p16b.carry", 64'(carry16), 64'h0);

        // Reset held for two edges.
        clk_en = 1'b1;
        rst    = 1'b1;
        pc_in  = 32'h100;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst.pc_out_q", 64'(pc_out_q), 64'h0);
            chk("rst.valid_q", 64'(valid_q), 64'h0);
            chk("rst.pc_out", 64'(pc_out), 64'h104);
        end
        rst = 1'b0;
        step();
        chk("rel.pc_out_q", 64'(pc_out_q), 64'h104);
        chk("rel.valid_q", 64'(valid_q), 64'h1);

        // Pipeline latency.
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(4 * i);
            step();
            chk("pipe.pc_out_q", 64'(pc_out_q), 64'(4 * i + 4));
            chk("pipe.carry_q", 64'(carry_q), 64'h0);
            chk("pipe.mis_q", 64'(misaligned_q), 64'h0);
        end

        // Mid-stream reset.
        pc_in = 32'hFFFF_FFFC;
        rst   = 1'b1;
        step();
        chk("mid.pc_out_q", 64'(pc_out_q), 64'h0);
        chk("mid.carry_q", 64'(carry_q), 64'h0);
        chk("mid.mis_q", 64'(misaligned_q), 64'h0);
        chk("mid.valid_q", 64'(valid_q), 64'h0);
        rst = 1'b0;
        step();
        chk("post.pc_out_q", 64'(pc_out_q), 64'h0);
        chk("post.carry_q", 64'(carry_q), 64'h1);
        chk("post.valid_q", 64'(valid_q), 64'h1);

        // Randomised traffic with occasional reset, biased toward the wrap region.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                pc_in = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                pc_in = $urandom;
            r   = ($urandom_range(0, 7) == 0);
            rst = r;
            #1;
            chk_comb("rnd.comb");
            m = model(pc_in);
            step();
            if (r) begin
                chk("rnd.pc_out_q", 64'(pc_out_q), 64'h0);
                chk("rnd.carry_q", 64'(carry_q), 64'h0);
                chk("rnd.mis_q", 64'(misaligned_q), 64'h0);
                chk("rnd.valid_q", 64'(valid_q), 64'h0);
            end else begin
                chk("rnd.pc_out_q", 64'(pc_out_q), 64'(m[31:0]));
                chk("rnd.carry_q", 64'(carry_q), 64'(m[32]));
                chk("rnd.mis_q", 64'(misaligned_q), 64'(m[33]));
                chk("rnd.valid_q", 64'(valid_q), 64'h1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/add_4.md
# add_4

PC-increment unit of the single-cycle RISC-V core: forms the sequential next-instruction address `pc_in + 4` combinationally, feeding the next-PC mux in the same cycle. It also provides a registered copy of that result plus status flags (carry/wrap, misalignment) for the core's debug and trace logic. The registered side is the only clocked state; the combinational sum has no dependence on clock or reset.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- `WIDTH`, default 32: address width in bits.
- `INC`, default 4: increment constant, one RV32 instruction.

**Ports**
- `clk`, input, 1: rising-edge clock for the registered outputs.
- `rst`, input, 1: synchronous, active-high reset of the registered outputs.
- `pc_in`, input, WIDTH: current program counter.
- `pc_out`, output, WIDTH: `pc_in + INC`, combinational.
- `carry`, output, 1: combinational carry-out of the addition; the sum wrapped past 2^WIDTH.
- `misaligned`, output, 1: combinational; high when `pc_in[1:0] != 0`.
- `pc_out_q`, output, WIDTH: `pc_out` registered on the rising edge of `clk`.
- `carry_q`, output, 1: `carry` registered.
- `misaligned_q`, output, 1: `misaligned` registered.
- `valid_q`, output, 1: high once at least one non-reset clock edge has captured data.

## Operation

- `pc_out = (pc_in + INC) mod 2^WIDTH`. Unsigned arithmetic; the carry-out is the (WIDTH+1)-th bit of the sum and is driven on `carry`.
- There is no alignment correction. Misaligned `pc_in` values are still incremented literally (0x2 gives 0x6, 0xF gives 0x13). `misaligned` only reports the condition.
- `pc_out`, `carry` and `misaligned` are pure functions of `pc_in`:
  - They are unaffected by `clk` and `rst`.
  - They are valid with no clock running.
  - They are not X-propagating beyond X bits present on `pc_in`.
- Registered path behaviour at each rising edge of `clk`:
  - `rst=1`: `pc_out_q=0`, `carry_q=0`, `misaligned_q=0`, `valid_q=0`.
  - `rst=0`: `pc_out_q<=pc_out`, `carry_q<=carry`, `misaligned_q<=misaligned`, `valid_q<=1`.
- No enable, no handshake. The registered path samples every cycle.

## Timing

- Combinational outputs: zero-cycle latency, settling within the same delta/propagation time as `pc_in`. Must meet the single-cycle critical path; implement the adder as a plain synthesizable `+`.
- Registered outputs: 1-cycle latency from `pc_in` to `pc_out_q`, `carry_q` and `misaligned_q`.
- Reset values: all registered outputs are 0. Combinational outputs have no reset value and always track `pc_in`, including while `rst=1`.
- Reset mid-operation: reset overrides capture on that edge. The first edge with `rst=0` afterwards captures the current `pc_in` and sets `valid_q`.
- Wrap-around: `pc_in=0xFFFFFFFC` gives `pc_out=0x00000000` and `carry=1`. `pc_in=0xFFFFFFFF` gives `pc_out=0x00000003` and `carry=1`.
- `pc_in` changing in the same cycle as the clock edge: the registered side captures the value settled before the edge, under standard setup rules.

## Test plan

- Combinational, no clock toggling, 10-unit spacing between stimuli:
  - `pc_in=0x2` -> `pc_out=0x6`, `misaligned=1`, `carry=0`.
  - `pc_in=0x0` -> `pc_out=0x4`, `misaligned=0`.
  - `pc_in=0xA` -> `pc_out=0xE`, `misaligned=1`.
  - `pc_in=0xF` -> `pc_out=0x13`, `misaligned=1`.
- Wrap:
  - `pc_in=0xFFFFFFFC` -> `pc_out=0x0`, `carry=1`.
  - `pc_in=0x7FFFFFFC` -> `pc_out=0x80000000`, `carry=0`.
- Reset:
  - Hold `rst=1` for 2 edges with `pc_in=0x100` -> `pc_out_q=0` and `valid_q=0`, while `pc_out=0x104` throughout.
  - Release `rst` -> after the next edge, `pc_out_q=0x104` and `valid_q=1`.
- Pipeline latency: drive `pc_in` = 0x0, 0x4, 0x8 on consecutive edges -> `pc_out_q` = 0x4, 0x8, 0xC, each one edge later; `carry_q` and `misaligned_q` stay 0.
- Mid-stream reset: assert `rst` for one edge while `pc_in=0xFFFFFFFC` -> registered outputs all 0 on that edge. The following edge with `rst=0` gives `pc_out_q=0x0` and `carry_q=1`.
- Parameter check: instantiate with `WIDTH=16`, `INC=2`, `pc_in=0xFFFF` -> `pc_out=0x0001`, `carry=1`.
